// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2,
    DONE    = 2'd3
  } arb_state_t;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_id_t;

  localparam logic [1:0] BE_WORD = 2'b11;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: on contention the port that did not win last time is chosen.
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic     i_req,
  input  logic     d_req,
  input  port_id_t last_grant,
  output logic     grant_valid,
  output port_id_t grant_id
);

  // Combinational grant selection
  always_comb begin
    grant_valid = i_req | d_req;
    grant_id    = PORT_D;
    if (i_req && d_req) begin
      grant_id = (last_grant == PORT_D) ? PORT_I : PORT_D;
    end else if (i_req) begin
      grant_id = PORT_I;
    end else begin
      grant_id = PORT_D;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Merges the read-only instruction port and the read/write data port onto one memory port,
// with registered memory strobes and registered one-cycle responses.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic              i_resp,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [1:0]        d_byte_enable,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_resp,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [1:0]        mem_byte_enable,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_resp,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_t        state_r;
  arb_state_t        state_next_s;
  port_id_t          last_grant_r;
  logic              pick_valid_s;
  port_id_t          pick_id_s;

  logic              mem_read_r;
  logic              mem_write_r;
  logic [1:0]        mem_be_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [DATA_W-1:0] mem_wdata_r;
  logic              i_resp_r;
  logic              d_resp_r;
  logic [DATA_W-1:0] i_rdata_r;
  logic [DATA_W-1:0] d_rdata_r;

  rr_pick2 u_pick (
    .i_req       (i_read),
    .d_req       (d_read | d_write),
    .last_grant  (last_grant_r),
    .grant_valid (pick_valid_s),
    .grant_id    (pick_id_s)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; DONE always spends exactly one cycle so memory can return to idle
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (pick_valid_s) begin
          state_next_s = (pick_id_s == PORT_I) ? GRANT_I : GRANT_D;
        end else begin
          state_next_s = IDLE;
        end
      end
      GRANT_I, GRANT_D: begin
        if (mem_resp) begin
          state_next_s = DONE;
        end else begin
          state_next_s = state_r;
        end
      end
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Memory request registers, response pulses and captured read data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_r <= PORT_D;
      mem_read_r   <= 1'b0;
      mem_write_r  <= 1'b0;
      mem_be_r     <= 2'b00;
      mem_addr_r   <= {ADDR_W{1'b0}};
      mem_wdata_r  <= {DATA_W{1'b0}};
      i_resp_r     <= 1'b0;
      d_resp_r     <= 1'b0;
      i_rdata_r    <= {DATA_W{1'b0}};
      d_rdata_r    <= {DATA_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (pick_valid_s) begin
            last_grant_r <= pick_id_s;
            if (pick_id_s == PORT_I) begin
              mem_read_r  <= 1'b1;
              mem_write_r <= 1'b0;
              mem_be_r    <= BE_WORD;
              mem_addr_r  <= i_address;
              mem_wdata_r <= {DATA_W{1'b0}};
            end else begin
              // A simultaneous read and write request is served as a write
              mem_read_r  <= ~d_write;
              mem_write_r <= d_write;
              mem_be_r    <= d_byte_enable;
              mem_addr_r  <= d_address;
              mem_wdata_r <= d_wdata;
            end
          end
        end
        GRANT_I: begin
          if (mem_resp) begin
            i_rdata_r   <= mem_rdata;
            i_resp_r    <= 1'b1;
            mem_read_r  <= 1'b0;
            mem_write_r <= 1'b0;
          end
        end
        GRANT_D: begin
          if (mem_resp) begin
            d_rdata_r   <= mem_rdata;
            d_resp_r    <= 1'b1;
            mem_read_r  <= 1'b0;
            mem_write_r <= 1'b0;
          end
        end
        DONE: begin
          i_resp_r <= 1'b0;
          d_resp_r <= 1'b0;
        end
        default: begin
          mem_read_r  <= 1'b0;
          mem_write_r <= 1'b0;
        end
      endcase
    end
  end

  assign mem_read        = mem_read_r;
  assign mem_write       = mem_write_r;
  assign mem_byte_enable = mem_be_r;
  assign mem_address     = mem_addr_r;
  assign mem_wdata       = mem_wdata_r;
  assign i_resp          = i_resp_r;
  assign i_rdata         = i_rdata_r;
  assign d_resp          = d_resp_r;
  assign d_rdata         = d_rdata_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench: directed cases plus randomized traffic against a transaction-level model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_read, d_read, d_write;
  logic [15:0] i_address, d_address, d_wdata, mem_rdata;
  logic [1:0]  d_byte_enable;
  logic        mem_resp;
  logic        i_resp, d_resp, mem_read, mem_write;
  logic [15:0] i_rdata, d_rdata, mem_address, mem_wdata;
  logic [1:0]  mem_byte_enable;

  int checks = 0;
  int errors = 0;

  // behavioural memory (environment) and the model's own view of memory contents
  logic [15:0] bmem [16];
  logic [15:0] ref_mem [16];
  int mem_state, mem_cnt, mem_delay;
  bit mem_manual, spur_en;

  // model: expected visible outputs
  logic        e_mem_read, e_mem_write, e_i_resp, e_d_resp;
  logic [1:0]  e_be;
  logic [15:0] e_addr, e_wdata, e_i_rdata, e_d_rdata;
  int          m_owner;  // 0 none, 1 I-port, 2 D-port in service
  int          m_last;   // port that won the previous grant

  mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .i_read(i_read), .i_address(i_address), .i_resp(i_resp), .i_rdata(i_rdata),
    .d_read(d_read), .d_write(d_write), .d_byte_enable(d_byte_enable),
    .d_address(d_address), .d_wdata(d_wdata), .d_resp(d_resp), .d_rdata(d_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_byte_enable(mem_byte_enable),
    .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_resp(mem_resp), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] nw,
                                        input logic [1:0] be);
    return {be[1] ? nw[15:8] : old[15:8], be[0] ? nw[7:0] : old[7:0]};
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    e_mem_read = 1'b0; e_mem_write = 1'b0; e_i_resp = 1'b0; e_d_resp = 1'b0;
    e_be = 2'b00; e_addr = 16'h0000; e_wdata = 16'h0000;
    e_i_rdata = 16'h0000; e_d_rdata = 16'h0000;
    m_owner = 0; m_last = 2;
  endtask

  // One clock edge of the arbiter's rules, applied to the inputs present before the edge
  task automatic model_step();
    int win;
    logic [15:0] data;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (m_owner != 0) begin
      if (mem_resp) begin
        if (e_mem_write) ref_mem[e_addr[4:1]] = merge(ref_mem[e_addr[4:1]], e_wdata, e_be);
        data = ref_mem[e_addr[4:1]];
        if (m_owner == 1) begin e_i_rdata = data; e_i_resp = 1'b1; end
        else begin e_d_rdata = data; e_d_resp = 1'b1; end
        e_mem_read = 1'b0; e_mem_write = 1'b0; m_owner = 0;
      end
    end else if (e_i_resp || e_d_resp) begin
      e_i_resp = 1'b0; e_d_resp = 1'b0;
    end else begin
      win = 0;
      if (i_read && (d_read || d_write)) win = (m_last == 2) ? 1 : 2;
      else if (i_read) win = 1;
      else if (d_read || d_write) win = 2;
      if (win == 1) begin
        e_mem_read = 1'b1; e_mem_write = 1'b0; e_be = 2'b11;
        e_addr = i_address; e_wdata = 16'h0000;
      end else if (win == 2) begin
        e_mem_read = !d_write; e_mem_write = d_write; e_be = d_byte_enable;
        e_addr = d_address; e_wdata = d_wdata;
      end
      if (win != 0) begin m_owner = win; m_last = win; end
    end
  endtask

  task automatic mem_step();
    if (mem_manual) return;
    mem_resp = 1'b0;
    if (mem_state == 2) begin
      mem_state = 0;
      if (spur_en && !mem_read && !mem_write && $urandom_range(0, 3) == 0) begin
        mem_resp = 1'b1; mem_rdata = 16'($urandom);
      end
    end else begin
      if (mem_state == 0 && (mem_read || mem_write)) begin
        mem_cnt = mem_delay; mem_state = 1;
      end
      if (mem_state == 1) begin
        if (mem_cnt == 0) begin
          if (mem_write)
            bmem[mem_address[4:1]] = merge(bmem[mem_address[4:1]], mem_wdata, mem_byte_enable);
          mem_rdata = bmem[mem_address[4:1]];
          mem_resp = 1'b1; mem_state = 2;
        end else begin
          mem_cnt--;
        end
      end else if (spur_en && $urandom_range(0, 15) == 0) begin
        mem_resp = 1'b1; mem_rdata = 16'($urandom);
      end
    end
  endtask

  task automatic compare_all();
    chk("mem_read", 16'(mem_read), 16'(e_mem_read));
    chk("mem_write", 16'(mem_write), 16'(e_mem_write));
    chk("i_resp", 16'(i_resp), 16'(e_i_resp));
    chk("d_resp", 16'(d_resp), 16'(e_d_resp));
    chk("i_rdata", i_rdata, e_i_rdata);
    chk("d_rdata", d_rdata, e_d_rdata);
    if (e_mem_read || e_mem_write) begin
      chk("mem_address", mem_address, e_addr);
      chk("mem_byte_enable", 16'(mem_byte_enable), 16'(e_be));
    end
    if (e_mem_write) chk("mem_wdata", mem_wdata, e_wdata);
  endtask

  // compare at the falling edge, then advance one rising edge; caller drives inputs afterwards
  task automatic cycle();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    model_step();
    #2;
    mem_step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    mem_state = 0; mem_resp = 1'b0;
    cycle();
    cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    int pulses, seen_i, seen_d, r, k;
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; d_byte_enable = 2'b00;
    i_address = 16'h0000; d_address = 16'h0000; d_wdata = 16'h0000;
    mem_resp = 1'b0; mem_rdata = 16'h0000;
    mem_manual = 1'b0; spur_en = 1'b0; mem_delay = 0; mem_state = 0;
    for (int i = 0; i < 16; i++) begin
      bmem[i] = 16'($urandom); ref_mem[i] = bmem[i];
    end
    rst_n = 1'b1;
    #1;
    do_reset();
    chk("reset_mem_read", 16'(mem_read), 16'h0000);
    chk("reset_mem_address", mem_address, 16'h0000);
    chk("reset_mem_be", 16'(mem_byte_enable), 16'h0000);
    chk("reset_d_rdata", d_rdata, 16'h0000);

    // I-only read
    bmem[8] = 16'h1234; ref_mem[8] = 16'h1234;
    i_read = 1'b1; i_address = 16'h0010;
    cycle();
    chk("iread_strobe", 16'(mem_read), 16'h0001);
    chk("iread_addr", mem_address, 16'h0010);
    chk("iread_be", 16'(mem_byte_enable), 16'h0003);
    cycle();
    chk("iread_resp", 16'(i_resp), 16'h0001);
    chk("iread_rdata", i_rdata, 16'h1234);
    chk("iread_no_dresp", 16'(d_resp), 16'h0000);
    chk("iread_strobe_drop", 16'(mem_read), 16'h0000);
    i_read = 1'b0;
    cycle();
    chk("iread_resp_end", 16'(i_resp), 16'h0000);

    // D byte write then read back
    bmem[0] = 16'h5566; ref_mem[0] = 16'h5566;
    d_write = 1'b1; d_byte_enable = 2'b01; d_address = 16'h0021; d_wdata = 16'hABCD;
    cycle();
    chk("dwr_strobe", 16'({mem_read, mem_write}), 16'h0001);
    chk("dwr_be", 16'(mem_byte_enable), 16'h0001);
    chk("dwr_addr", mem_address, 16'h0021);
    cycle();
    chk("dwr_resp", 16'(d_resp), 16'h0001);
    d_write = 1'b0;
    cycle();
    chk("dwr_resp_end", 16'(d_resp), 16'h0000);
    d_read = 1'b1; d_address = 16'h0020;
    cycle();
    cycle();
    chk("drd_rdata", d_rdata, 16'h55CD);
    chk("model_pin_drd", e_d_rdata, 16'h55CD);
    d_read = 1'b0;
    cycle();

    // Simultaneous requests after reset: I first, D next, and again I first
    do_reset();
    for (int rep = 0; rep < 2; rep++) begin
      i_read = 1'b1; i_address = 16'h0010; d_read = 1'b1; d_address = 16'h0020;
      cycle();
      chk("rr_first_is_i", mem_address, 16'h0010);
      seen_i = 0; seen_d = 0;
      for (int c = 0; c < 12 && !(seen_i == 1 && seen_d == 1); c++) begin
        cycle();
        if (i_resp) begin
          seen_i++; i_read = 1'b0;
          cycle();
          chk("rr_gap_strobe_low", 16'(mem_read), 16'h0000);
          cycle();
          chk("rr_then_d", {mem_read, mem_address[14:0]}, 16'h8020);
        end
        if (d_resp) begin seen_d++; d_read = 1'b0; end
      end
      chk("rr_both_served", 16'(seen_i + seen_d), 16'h0002);
      cycle();
    end

    // Reset during a D transfer; stale memory response afterwards is dropped
    mem_manual = 1'b1; mem_resp = 1'b0;
    d_read = 1'b1; d_address = 16'h0030;
    cycle();
    chk("rstmid_grant", 16'(mem_read), 16'h0001);
    d_read = 1'b0; rst_n = 1'b0; model_reset();
    cycle();
    rst_n = 1'b1;
    cycle();
    mem_resp = 1'b1; mem_rdata = 16'hDEAD;
    cycle();
    mem_resp = 1'b0;
    chk("rstmid_no_dresp", 16'(d_resp), 16'h0000);
    cycle();
    chk("rstmid_d_rdata", d_rdata, 16'h0000);
    chk("rstmid_strobes", 16'({mem_read, mem_write}), 16'h0000);
    chk("rstmid_addr", mem_address, 16'h0000);
    chk("rstmid_wdata", mem_wdata, 16'h0000);
    mem_manual = 1'b0; mem_state = 0;

    // Request withdrawn mid-transfer
    mem_delay = 2;
    i_read = 1'b1; i_address = 16'h0040;
    cycle();
    i_read = 1'b0;
    pulses = 0;
    for (int c = 0; c < 8; c++) begin
      cycle();
      if (i_resp) pulses++;
    end
    chk("withdraw_one_pulse", 16'(pulses), 16'h0001);

    // Randomized traffic
    spur_en = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      mem_delay = $urandom_range(0, 3);
      cycle();
      if (i_resp) i_read = 1'b0;
      else if (!i_read) begin
        if ($urandom_range(0, 2) == 0) begin i_read = 1'b1; i_address = 16'($urandom); end
      end else begin
        r = $urandom_range(0, 31);
        if (r == 0) i_read = 1'b0;
        else if (r == 1) i_address = 16'($urandom);
      end
      if (d_resp) begin d_read = 1'b0; d_write = 1'b0; end
      else if (!(d_read || d_write)) begin
        if ($urandom_range(0, 2) == 0) begin
          k = $urandom_range(0, 3);
          d_read = (k == 0) || (k == 3); d_write = (k != 0);
          d_byte_enable = 2'($urandom); d_address = 16'($urandom); d_wdata = 16'($urandom);
        end
      end else begin
        r = $urandom_range(0, 31);
        if (r == 0) begin d_read = 1'b0; d_write = 1'b0; end
        else if (r == 1) begin d_address = 16'($urandom); d_wdata = 16'($urandom); end
      end
    end
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
    repeat (10) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
